// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared state encoding and MISR polynomial for the gate response checker.
package gate_check_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [63:0] MISR_POLY64 = 64'h1B;
endpackage

// File: rtl/gate_misr.sv
// gate_misr: multiple-input signature register folding one word per enabled cycle.
module gate_misr #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] POLY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else if (clr) sig <= '0;
    else if (en) sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
endmodule

// File: rtl/gate_check.sv
// gate_check: 2-stage AND-gate response checker with error counting and first-failure capture.
// Optional MISR signature when GATE_CHECK_MISR_EN is defined; otherwise signature is tied to 0.
module gate_check
  import gate_check_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] signature
);
  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic             r_v1;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_got;
  logic [CNT_W-1:0] r_idx;
  logic             w_start;
  logic             w_acc;
  logic             w_mis;
  assign w_start = start && (r_state == IDLE || r_state == DONE);
  assign w_acc   = r_state == RUN && vld_in && vec_cnt < r_num;
  assign w_mis   = r_v1 && r_exp != r_got;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state       <= IDLE;
      r_num         <= '0;
      r_v1          <= 1'b0;
      r_exp         <= '0;
      r_got         <= '0;
      r_idx         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_exp   <= in1 & in2;
        r_got   <= dut_out;
        r_idx   <= vec_cnt;
        vec_cnt <= vec_cnt + 1'b1;
      end
      // err_cnt is zero only until the first mismatch of a run, so it doubles as the capture flag
      if (w_mis) begin
        err_cnt <= &err_cnt ? err_cnt : err_cnt + 1'b1;
        if (err_cnt == '0) begin
          first_err_idx <= r_idx;
          first_err_exp <= r_exp;
          first_err_got <= r_got;
        end
      end
      case (r_state)
        IDLE, DONE: if (start) begin
          r_num         <= num_vec;
          vec_cnt       <= '0;
          err_cnt       <= '0;
          first_err_idx <= '0;
          first_err_exp <= '0;
          first_err_got <= '0;
          busy          <= 1'b1;
          done          <= 1'b0;
          pass          <= 1'b0;
          r_state       <= num_vec == '0 ? DRAIN : RUN;
        end
        RUN: if (w_acc && vec_cnt + 1'b1 == r_num) r_state <= DRAIN;
        DRAIN: if (!r_v1) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= err_cnt == '0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
`ifdef GATE_CHECK_MISR_EN
  gate_misr #(.WIDTH(WIDTH), .POLY(WIDTH'(MISR_POLY64))) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (w_start),
    .en  (r_v1),
    .din (r_got),
    .sig (signature)
  );
`else
  assign signature = '0;
`endif
endmodule

// File: tb/tb_gate_check.sv
// tb_gate_check: randomized and directed runs against a run-level reference model.
module tb_gate_check;
  localparam int W = 64;
  localparam int C = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, vld_in = 1'b0;
  logic [C-1:0] num_vec = '0;
  logic [W-1:0] in1 = '0, in2 = '0, dut_out = '0;
  logic busy, done, pass;
  logic [C-1:0] vec_cnt, err_cnt, first_err_idx;
  logic [W-1:0] first_err_exp, first_err_got, signature;
  int checks = 0, errors = 0;
  logic [W-1:0] v1 [64];
  logic [W-1:0] v2 [64];
  logic [W-1:0] vo [64];

  always #5 clk = ~clk;

  gate_check #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .vld_in(vld_in),
    .in1(in1), .in2(in2), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got), .signature(signature)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic junk(input logic v);
    vld_in  = v;
    in1     = {$urandom, $urandom};
    in2     = {$urandom, $urandom};
    dut_out = {$urandom, $urandom};
  endtask

  task automatic gen(input int n, input int err_pct);
    for (int k = 0; k < n; k++) begin
      v1[k] = {$urandom, $urandom};
      v2[k] = {$urandom, $urandom};
      vo[k] = v1[k] & v2[k];
      if ($urandom_range(99) < err_pct) vo[k] ^= 64'd1 << $urandom_range(63);
    end
  endtask

  task automatic run(input int n, input int gap_pct, input bit mid_start);
    int e = 0, fi = 0, i = 0, cyc = 0;
    logic [63:0] fe = '0, fg = '0, sig = '0;
    for (int k = 0; k < n; k++) begin
      if (vo[k] != (v1[k] & v2[k])) begin
        if (e == 0) begin fi = k; fe = v1[k] & v2[k]; fg = vo[k]; end
        e++;
      end
      sig = {sig[62:0], 1'b0} ^ (sig[63] ? 64'h1B : 64'h0) ^ vo[k];
    end
`ifndef GATE_CHECK_MISR_EN
    sig = '0;
`endif
    @(negedge clk);
    start = 1'b1;
    num_vec = n;
    @(negedge clk);
    start = 1'b0;
    num_vec = $urandom;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("vec_cnt_cleared", vec_cnt, 0);
    check("err_cnt_cleared", err_cnt, 0);
    if (n == 0) begin
      junk(1'b1);
      @(negedge clk);
      check("zero_done", done, 1);
    end else begin
      while (i < n && cyc < 1000) begin
        junk($urandom_range(99) >= gap_pct);
        if (vld_in) begin in1 = v1[i]; in2 = v2[i]; dut_out = vo[i]; end
        start = mid_start && i == 1;
        num_vec = $urandom_range(1, 100);
        @(negedge clk);
        cyc++;
        if (vld_in) i++;
        start = 1'b0;
        check("vec_cnt_run", vec_cnt, i);
        check("done_early", done, 0);
      end
      if (cyc >= 1000) check("run_timeout", 0, 1);
      junk(1'b1);
      @(negedge clk);
      check("done_t2", done, 0);
      check("err_cnt_t2", err_cnt, e);
      junk(1'b1);
      @(negedge clk);
      check("done_t3", done, 1);
    end
    junk(1'b0);
    check("busy_end", busy, 0);
    check("pass", pass, e == 0);
    check("vec_cnt_end", vec_cnt, n);
    check("err_cnt_end", err_cnt, e);
    check("first_err_idx", first_err_idx, fi);
    check("first_err_exp", first_err_exp, fe);
    check("first_err_got", first_err_got, fg);
    check("signature", signature, sig);
    repeat (3) begin junk(1'b1); @(negedge clk); end
    junk(1'b0);
    check("done_held", done, 1);
    check("vec_cnt_held", vec_cnt, n);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_vec_cnt", vec_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_idx", first_err_idx, 0);
    check("rst_first_exp", first_err_exp, 0);
    check("rst_first_got", first_err_got, 0);
    check("rst_signature", signature, 0);
    rst = 1'b0;
    // abort a run after three vectors, all of them mismatching
    gen(8, 100);
    @(negedge clk);
    start = 1'b1;
    num_vec = 8;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld_in = 1'b1; in1 = v1[k]; in2 = v2[k]; dut_out = vo[k];
      @(negedge clk);
    end
    junk(1'b0);
    check("mid_vec_cnt", vec_cnt, 3);
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_vec_cnt", vec_cnt, 0);
    check("abort_err_cnt", err_cnt, 0);
    check("abort_signature", signature, 0);
    rst = 1'b0;
    gen(4, 0);
    run(4, 0, 1'b0);
    gen(5, 0);
    v1[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    v2[2] = 64'h0F0F_0F0F_0F0F_0F0F;
    vo[2] = 64'h0;
    vo[4] = ~vo[4];
    run(5, 0, 1'b0);
    check("dir_first_idx", first_err_idx, 2);
    check("dir_first_exp", first_err_exp, 64'h0F0F_0F0F_0F0F_0F0F);
    check("dir_err_cnt", err_cnt, 2);
    run(0, 0, 1'b0);
    check("zero_pass", pass, 1);
    gen(2, 0);
    run(2, 50, 1'b1);
    v1[0] = 64'd1; v2[0] = 64'd1; vo[0] = 64'd1;
    v1[1] = 64'd0; v2[1] = 64'd0; vo[1] = 64'd0;
    run(2, 0, 1'b0);
    repeat (20) begin
      int n;
      n = $urandom_range(1, 30);
      gen(n, 20);
      run(n, $urandom_range(0, 60), n >= 2 && $urandom_range(1) == 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
